// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: opcode constants, the
// per-instruction control bundle and the forwarding select encoding.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Every control bit an instruction carries down the pipe
    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       branch;
        logic       jalsel;
        logic       jalrsel;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Operand source select presented to the EX stage
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, legality and which source
// registers the instruction actually reads.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       legal_o,
    output logic       use_rs1_o,
    output logic       use_rs2_o
);

    logic is_r, is_i, is_lw, is_sw, is_br, is_lui, is_jal, is_jalr;

    // Opcode match and control equations; illegal opcodes yield all-zero controls
    always_comb begin
        is_r    = (opcode_i == OP_R);
        is_i    = (opcode_i == OP_I);
        is_lw   = (opcode_i == OP_LW);
        is_sw   = (opcode_i == OP_SW);
        is_br   = (opcode_i == OP_BR);
        is_lui  = (opcode_i == OP_LUI);
        is_jal  = (opcode_i == OP_JAL);
        is_jalr = (opcode_i == OP_JALR);

        legal_o = is_r | is_i | is_lw | is_sw | is_br | is_lui | is_jal | is_jalr;

        ctrl_o          = CTRL_NOP;
        ctrl_o.alusrc   = is_lw | is_sw | is_i | is_lui;
        ctrl_o.memtoreg = is_lw;
        ctrl_o.memread  = is_lw;
        ctrl_o.memwrite = is_sw;
        ctrl_o.regwrite = is_r | is_lw | is_i | is_lui | is_jal | is_jalr;
        ctrl_o.aluop[0] = is_br | is_lui | is_jal | is_jalr;
        ctrl_o.aluop[1] = is_r | is_i | is_lui;
        ctrl_o.branch   = is_br | is_jal | is_jalr;
        ctrl_o.jalsel   = is_jal | is_jalr;
        ctrl_o.jalrsel  = is_jalr;

        // LUI and JAL carry no rs1; only R, SW and BR read rs2
        use_rs1_o = legal_o & ~is_lui & ~is_jal;
        use_rs2_o = is_r | is_sw | is_br;
    end

endmodule

// File: rtl/pipe_controller.sv
// Pipeline controller for a 5-stage in-order core: decodes the ID
// instruction, carries its controls through ID/EX, EX/MEM and MEM/WB,
// detects data hazards, squashes IF/ID on taken branches and counts stalls.
// Build option PIPE_CTRL_FWD_EN: with it, EX operands are forwarded from MEM/WB
// and only load-use stalls; without it, any RAW dependence on EX or MEM stalls.
module pipe_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              ex_valid,
    output logic              ex_alusrc,
    output logic [1:0]        ex_aluop,
    output logic              ex_branch,
    output logic              ex_jalsel,
    output logic              ex_jalrsel,
    output logic              mem_valid,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  stall_count
);

    ctrl_t dec_ctrl;
    logic  dec_legal, dec_use_rs1, dec_use_rs2;

    ctrl_decode u_decode (
        .opcode_i  (id_opcode),
        .ctrl_o    (dec_ctrl),
        .legal_o   (dec_legal),
        .use_rs1_o (dec_use_rs1),
        .use_rs2_o (dec_use_rs2)
    );

    // ID/EX
    logic              ex_valid_q, ex_valid_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
`ifdef PIPE_CTRL_FWD_EN
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
`endif
    // EX/MEM
    logic              mem_valid_q, mem_memread_q, mem_memwrite_q;
    logic              mem_regwrite_q, mem_memtoreg_q;
    logic [REG_AW-1:0] mem_rd_q;
    // MEM/WB
    logic              wb_valid_q, wb_regwrite_q, wb_memtoreg_q;
    logic [REG_AW-1:0] wb_rd_q;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic     id_live, need_rs1, need_rs2;
    logic     hazard_c, flush_c, stall_c, ex_bubble;
    fwd_sel_e fwd_a_c, fwd_b_c;

    // Hazard, flush and forwarding decisions for the current cycle
    always_comb begin
        id_live  = id_valid & dec_legal;
        need_rs1 = id_live & dec_use_rs1;
        need_rs2 = id_live & dec_use_rs2;
        flush_c  = ex_valid_q & ex_ctrl_q.branch & ex_branch_taken;
        hazard_c = 1'b0;
        fwd_a_c  = FWD_NONE;
        fwd_b_c  = FWD_NONE;
`ifdef PIPE_CTRL_FWD_EN
        // Only a load in EX cannot be forwarded in time
        if (ex_valid_q && ex_ctrl_q.memread && (ex_rd_q != '0)) begin
            hazard_c = (need_rs1 && (ex_rd_q == id_rs1)) ||
                       (need_rs2 && (ex_rd_q == id_rs2));
        end
        // MEM is younger than WB, so it wins when both match
        if (mem_valid_q && mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q))
            fwd_a_c = FWD_MEM;
        else if (wb_valid_q && wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q))
            fwd_a_c = FWD_WB;
        if (mem_valid_q && mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q))
            fwd_b_c = FWD_MEM;
        else if (wb_valid_q && wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q))
            fwd_b_c = FWD_WB;
`else
        // No bypass: wait until the producer reaches WB (write-through regfile)
        if (ex_valid_q && ex_ctrl_q.regwrite && (ex_rd_q != '0)) begin
            hazard_c = (need_rs1 && (ex_rd_q == id_rs1)) ||
                       (need_rs2 && (ex_rd_q == id_rs2));
        end
        if (mem_valid_q && mem_regwrite_q && (mem_rd_q != '0)) begin
            hazard_c = hazard_c ||
                       (need_rs1 && (mem_rd_q == id_rs1)) ||
                       (need_rs2 && (mem_rd_q == id_rs2));
        end
`endif
        // A taken branch discards the ID instruction, so stalling it is moot
        stall_c = hazard_c & ~flush_c;
    end

    // ID/EX next state: bubble on stall, flush, empty or illegal ID slot
    always_comb begin
        ex_bubble  = stall_c | flush_c | ~id_live;
        ex_valid_d = ~ex_bubble;
        ex_ctrl_d  = ex_bubble ? CTRL_NOP : dec_ctrl;
        ex_rd_d    = ex_bubble ? '0 : id_rd;
`ifdef PIPE_CTRL_FWD_EN
        // Unused operands are stored as x0 so they never select a bypass
        ex_rs1_d   = (ex_bubble || !dec_use_rs1) ? '0 : id_rs1;
        ex_rs2_d   = (ex_bubble || !dec_use_rs2) ? '0 : id_rs2;
`endif
        stall_cnt_d = (stall_c && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                       : stall_cnt_q;
    end

    // Stage registers advance every cycle regardless of stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= CTRL_NOP;
            ex_rd_q        <= '0;
`ifdef PIPE_CTRL_FWD_EN
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
`endif
            mem_valid_q    <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_rd_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_rd_q        <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_rd_q        <= ex_rd_d;
`ifdef PIPE_CTRL_FWD_EN
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
`endif
            mem_valid_q    <= ex_valid_q;
            mem_memread_q  <= ex_ctrl_q.memread;
            mem_memwrite_q <= ex_ctrl_q.memwrite;
            mem_regwrite_q <= ex_ctrl_q.regwrite;
            mem_memtoreg_q <= ex_ctrl_q.memtoreg;
            mem_rd_q       <= ex_rd_q;
            wb_valid_q     <= mem_valid_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_memtoreg_q  <= mem_memtoreg_q;
            wb_rd_q        <= mem_rd_q;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall        = stall_c;
    assign flush_ifid   = flush_c;
    assign illegal_op   = id_valid & ~dec_legal;
    assign ex_valid     = ex_valid_q;
    assign ex_alusrc    = ex_ctrl_q.alusrc;
    assign ex_aluop     = ex_ctrl_q.aluop;
    assign ex_branch    = ex_ctrl_q.branch;
    assign ex_jalsel    = ex_ctrl_q.jalsel;
    assign ex_jalrsel   = ex_ctrl_q.jalrsel;
    assign ex_rd        = ex_rd_q;
    assign mem_valid    = mem_valid_q;
    assign mem_memread  = mem_memread_q;
    assign mem_memwrite = mem_memwrite_q;
    assign mem_rd       = mem_rd_q;
    assign wb_valid     = wb_valid_q;
    assign wb_regwrite  = wb_regwrite_q;
    assign wb_memtoreg  = wb_memtoreg_q;
    assign wb_rd        = wb_rd_q;
    assign fwd_a        = fwd_a_c;
    assign fwd_b        = fwd_b_c;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller. Expected stage bundles are pushed when an
// instruction is presented in ID and popped when it should appear in EX; MEM/WB
// expectations follow from the popped entries. Works with or without
// PIPE_CTRL_FWD_EN defined.
module tb_pipe_controller;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;
    localparam int EW     = 16;
    localparam int SAT    = (2 ** CNT_W) - 1;
`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD   = 1'b1;
    localparam int ITERS = 260;
`else
    localparam bit FWD   = 1'b0;
    localparam int ITERS = 130;
`endif

    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_I    = 7'b0010011;
    localparam logic [6:0] T_LW   = 7'b0000011;
    localparam logic [6:0] T_SW   = 7'b0100011;
    localparam logic [6:0] T_BR   = 7'b1100011;
    localparam logic [6:0] T_LUI  = 7'b0110111;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_JALR = 7'b1100111;
    localparam logic [6:0] T_BAD  = 7'b1111111;
    localparam logic [6:0] PROD_OP = FWD ? T_LW : T_R;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] SW_ = 2'b01;
    localparam logic [1:0] SM = 2'b10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [6:0]        id_opcode = '0;
    logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic              ex_branch_taken = 1'b0;
    logic              stall, flush_ifid, ex_valid, ex_alusrc, ex_branch, ex_jalsel, ex_jalrsel;
    logic [1:0]        ex_aluop, fwd_a, fwd_b;
    logic              mem_valid, mem_memread, mem_memwrite, wb_valid, wb_regwrite, wb_memtoreg;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic              illegal_op;
    logic [CNT_W-1:0]  stall_count;

    int vectors = 0;
    int errors  = 0;
    int exp_cnt = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_ex = '0, exp_mem = '0, exp_wb = '0;

    // clock
    always #5 clk = ~clk;

    pipe_controller #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush_ifid(flush_ifid), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc),
        .ex_aluop(ex_aluop), .ex_branch(ex_branch), .ex_jalsel(ex_jalsel), .ex_jalrsel(ex_jalrsel),
        .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .illegal_op(illegal_op), .stall_count(stall_count)
    );

    // Reference decode table; layout {v, alusrc, aluop[1:0], branch, jalsel,
    // jalrsel, memread, memwrite, regwrite, memtoreg, rd[4:0]}
    function automatic logic [EW-1:0] tbl(input logic [6:0] op);
        case (op)
            T_R:     tbl = 16'b1_0_10_000_0010_00000;
            T_I:     tbl = 16'b1_1_10_000_0010_00000;
            T_LW:    tbl = 16'b1_1_00_000_1011_00000;
            T_SW:    tbl = 16'b1_1_00_000_0100_00000;
            T_BR:    tbl = 16'b1_0_01_100_0000_00000;
            T_LUI:   tbl = 16'b1_1_11_000_0010_00000;
            T_JAL:   tbl = 16'b1_0_01_110_0010_00000;
            T_JALR:  tbl = 16'b1_0_01_111_0010_00000;
            default: tbl = '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a cycle and check both the combinational
    // outputs of this cycle and the stage registers after the edge
    task automatic step(input logic v, input logic [6:0] op,
                        input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                        input logic [REG_AW-1:0] rs2, input logic tk,
                        input logic es, input logic ef, input logic [1:0] fa, input logic [1:0] fb);
        logic [EW-1:0] e;
        logic          ill;
        id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        ex_branch_taken = tk;
        #1;
        e   = tbl(op);
        ill = v & ~e[15];
        chk("stall", 32'(stall), 32'(es));
        chk("flush_ifid", 32'(flush_ifid), 32'(ef));
        chk("fwd_a", 32'(fwd_a), 32'(fa));
        chk("fwd_b", 32'(fwd_b), 32'(fb));
        chk("illegal_op", 32'(illegal_op), 32'(ill));
        if (!v || es || ef || !e[15]) e = '0;
        else e[4:0] = rd;
        exp_q.push_back(e);
        if (es && exp_cnt < SAT) exp_cnt++;
        @(posedge clk);
        #1;
        ex_branch_taken = 1'b0;
        exp_wb  = exp_mem;
        exp_mem = exp_ex;
        exp_ex  = exp_q.pop_front();
        chk("ex_ctrl", 32'({ex_valid, ex_alusrc, ex_aluop, ex_branch, ex_jalsel, ex_jalrsel}),
            32'(exp_ex[15:9]));
        if (exp_ex[15]) chk("ex_rd", 32'(ex_rd), 32'(exp_ex[4:0]));
        chk("mem_ctrl", 32'({mem_valid, mem_memread, mem_memwrite}),
            32'({exp_mem[15], exp_mem[8:7]}));
        if (exp_mem[15]) chk("mem_rd", 32'(mem_rd), 32'(exp_mem[4:0]));
        chk("wb_ctrl", 32'({wb_valid, wb_regwrite, wb_memtoreg}),
            32'({exp_wb[15], exp_wb[6:5]}));
        if (exp_wb[15]) chk("wb_rd", 32'(wb_rd), 32'(exp_wb[4:0]));
    endtask

    task automatic nop(input logic [1:0] fa, input logic [1:0] fb);
        step(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, fa, fb);
    endtask

    task automatic zero_checks(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_flush"}, 32'(flush_ifid), 32'd0);
        chk({tag, "_fwd"}, 32'({fwd_a, fwd_b}), 32'd0);
        chk({tag, "_ex"}, 32'({ex_valid, ex_alusrc, ex_aluop, ex_branch, ex_jalsel, ex_jalrsel}), 32'd0);
        chk({tag, "_mem"}, 32'({mem_valid, mem_memread, mem_memwrite}), 32'd0);
        chk({tag, "_wb"}, 32'({wb_valid, wb_regwrite, wb_memtoreg}), 32'd0);
        chk({tag, "_rd"}, 32'({ex_rd, mem_rd, wb_rd}), 32'd0);
        chk({tag, "_count"}, 32'(stall_count), 32'd0);
    endtask

    initial begin
        // reset state
        #12;
        zero_checks("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nop(S0, S0);
        nop(S0, S0);

        // decode sweep over every legal opcode, no dependences
        step(1, T_R,    5'd10, 5'd1, 5'd2, 0, 0, 0, S0, S0);
        step(1, T_I,    5'd11, 5'd3, 5'd0, 0, 0, 0, S0, S0);
        step(1, T_LW,   5'd12, 5'd4, 5'd0, 0, 0, 0, S0, S0);
        step(1, T_SW,   5'd13, 5'd5, 5'd6, 0, 0, 0, S0, S0);
        step(1, T_BR,   5'd0,  5'd7, 5'd8, 0, 0, 0, S0, S0);
        step(1, T_LUI,  5'd14, 5'd0, 5'd0, 0, 0, 0, S0, S0);
        step(1, T_JAL,  5'd15, 5'd0, 5'd0, 0, 0, 0, S0, S0);
        step(1, T_JALR, 5'd16, 5'd9, 5'd0, 0, 0, 0, S0, S0);
        nop(S0, S0);
        nop(S0, S0);
        nop(S0, S0);

        // x0 never hazards or forwards; illegal opcode becomes a bubble
        step(1, T_I,   5'd0, 5'd1, 5'd0, 0, 0, 0, S0, S0);
        step(1, T_R,   5'd1, 5'd0, 5'd0, 0, 0, 0, S0, S0);
        step(1, T_BAD, 5'd2, 5'd3, 5'd4, 0, 0, 0, S0, S0);
        nop(S0, S0);

`ifdef PIPE_CTRL_FWD_EN
        // ALU-ALU dependence resolved by MEM bypass on both operands
        step(1, T_R, 5'd3, 5'd1, 5'd2, 0, 0, 0, S0, S0);
        step(1, T_R, 5'd4, 5'd3, 5'd3, 0, 0, 0, S0, S0);
        nop(SM, SM);
        chk("count_after_alu", 32'(stall_count), 32'd0);
        nop(S0, S0);
        nop(S0, S0);
        // load-use: one stall, then WB bypass
        step(1, T_LW, 5'd5, 5'd4, 5'd0, 0, 0, 0, S0, S0);
        step(1, T_R,  5'd6, 5'd5, 5'd7, 0, 1, 0, S0, S0);
        step(1, T_R,  5'd6, 5'd5, 5'd7, 0, 0, 0, S0, S0);
        nop(SW_, S0);
        chk("count_after_lu", 32'(stall_count), 32'd1);
`else
        // no bypass: RAW on EX then MEM stalls exactly two cycles
        step(1, T_R, 5'd3, 5'd1, 5'd2, 0, 0, 0, S0, S0);
        step(1, T_R, 5'd4, 5'd3, 5'd1, 0, 1, 0, S0, S0);
        step(1, T_R, 5'd4, 5'd3, 5'd1, 0, 1, 0, S0, S0);
        step(1, T_R, 5'd4, 5'd3, 5'd1, 0, 0, 0, S0, S0);
        chk("count_after_alu", 32'(stall_count), 32'd2);
        nop(S0, S0);
        nop(S0, S0);
        nop(S0, S0);
        step(1, T_LW, 5'd5, 5'd4, 5'd0, 0, 0, 0, S0, S0);
        step(1, T_R,  5'd6, 5'd5, 5'd7, 0, 1, 0, S0, S0);
        step(1, T_R,  5'd6, 5'd5, 5'd7, 0, 1, 0, S0, S0);
        step(1, T_R,  5'd6, 5'd5, 5'd7, 0, 0, 0, S0, S0);
        nop(S0, S0);
        chk("count_after_lu", 32'(stall_count), 32'd4);
`endif
        nop(S0, S0);
        nop(S0, S0);
        nop(S0, S0);

        // taken branch in EX while ID depends on a load: flush wins
        step(1, T_LW, 5'd5, 5'd4, 5'd0, 0, 0, 0, S0, S0);
        step(1, T_BR, 5'd0, 5'd8, 5'd9, 0, 0, 0, S0, S0);
        step(1, T_R,  5'd6, 5'd5, 5'd7, 1, 0, 1, S0, S0);
        nop(S0, S0);
        chk("count_after_flush", 32'(stall_count), 32'(exp_cnt));
        nop(S0, S0);
        nop(S0, S0);

        // drive the counter past saturation
        for (int i = 0; i < ITERS; i++) begin
            step(1, PROD_OP, 5'd3, 5'd1, 5'd2, 0, 0, 0, (FWD && i > 0) ? SW_ : S0, S0);
            step(1, T_R, 5'd5, 5'd3, 5'd0, 0, 1, 0, S0, S0);
`ifndef PIPE_CTRL_FWD_EN
            step(1, T_R, 5'd5, 5'd3, 5'd0, 0, 1, 0, S0, S0);
`endif
            step(1, T_R, 5'd5, 5'd3, 5'd0, 0, 0, 0, S0, S0);
        end
        chk("count_saturated", 32'(stall_count), 32'(SAT));

        // asynchronous reset in the middle of a stall
        step(1, PROD_OP, 5'd3, 5'd1, 5'd2, 0, 0, 0, FWD ? SW_ : S0, S0);
        id_valid = 1'b1; id_opcode = T_R; id_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd0;
        #1;
        chk("stall_before_reset", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        zero_checks("midstall_reset");
        exp_q.delete();
        exp_ex = '0; exp_mem = '0; exp_wb = '0; exp_cnt = 0;
        @(posedge clk);
        #1;
        zero_checks("held_reset");
        rst_n = 1'b1;

        // first edge after release captures ID
        step(1, T_I, 5'd7, 5'd1, 5'd0, 0, 0, 0, S0, S0);
        nop(S0, S0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter REG_AW, default 5: register-index width.
REQ-002 Parameter CNT_W, default 16: stall performance counter width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_opcode  input  7  opcode of ID instruction.
REQ-007 id_rs1, id_rs2, id_rd  input  REG_AW each  register indices of ID instruction.
REQ-008 ex_branch_taken  input  1  EX-stage redirect; honoured only when ex_valid and ex_branch are both 1.
REQ-009 stall  output  1  hold PC and IF/ID this cycle; combinational.
REQ-010 flush_ifid  output  1  squash IF/ID this cycle; combinational.
REQ-011 ex_valid, ex_alusrc, ex_aluop[1:0], ex_branch, ex_jalsel, ex_jalrsel  output  ID/EX control bundle.
REQ-012 mem_valid, mem_memread, mem_memwrite  output  EX/MEM control bundle.
REQ-013 wb_valid, wb_regwrite, wb_memtoreg  output  MEM/WB control bundle.
REQ-014 ex_rd, mem_rd, wb_rd  output  REG_AW each  destination index per stage.
REQ-015 fwd_a, fwd_b  output  2 each  operand source select for EX.
REQ-016 illegal_op  output  1  ID opcode not in decode table while id_valid; combinational.
REQ-017 stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-018 Decode: R=0110011, I=0010011, LW=0000011, SW=0100011, BR=1100011, LUI=0110111, JAL=1101111, JALR=1100111.
REQ-019 ALUSrc=LW|SW|I|LUI; MemtoReg=MemRead=LW; MemWrite=SW; RegWrite=R|LW|I|LUI|JAL|JALR; ALUOp[0]=BR|LUI|JAL|JALR; ALUOp[1]=R|I|LUI; Branch=BR|JAL|JALR; JalSel=JAL|JALR; JalrSel=JALR.
REQ-020 Illegal opcode: all controls 0, enters pipe as bubble (valid 0).
REQ-021 Operand use: rs1 used by all legal opcodes except LUI and JAL; rs2 used by R, SW, BR only; unused operands never cause hazards.
REQ-022 Latency: controls of instruction decoded in cycle N appear on ex_* at N+1, mem_* at N+2, wb_* at N+3.
REQ-023 Each stage register advances every cycle; stall never freezes ID/EX onward.
REQ-024 Load-use: stall=1 when id_valid, ex_valid, ex_memread, ex_rd!=0 and ex_rd equals a used rs.
REQ-025 Stall: ID/EX loads a bubble (valid and all controls 0); ID instruction re-presented next cycle.
REQ-026 Flush: flush_ifid=ex_valid&ex_branch&ex_branch_taken; next-cycle ID/EX loads a bubble.
REQ-027 Flush has priority over stall: stall forced 0 whenever flush_ifid=1.
REQ-028 Forwarding (ID/EX registered rs1/rs2): 2'b10 if mem_valid&mem_regwrite&mem_rd!=0&mem_rd==rs; else 2'b01 if wb_valid&wb_regwrite&wb_rd!=0&wb_rd==rs; else 2'b00.
REQ-029 Index 0 never matches any hazard or forward comparison.
REQ-030 stall_count increments each cycle stall=1; holds at all-ones.

Reset
REQ-031 rst_n low asynchronously clears all valid bits, controls, rd fields, stored rs fields and stall_count to 0.
REQ-032 Outputs during reset: stall=0, flush_ifid=0, fwd_a=fwd_b=0; reset mid-stall drops the stall immediately.
REQ-033 First clock edge after rst_n release captures ID normally.

Configuration
REQ-034 Macro PIPE_CTRL_FWD_EN defined: forwarding per REQ-028, stalls only per REQ-024.
REQ-035 Macro absent: fwd_a=fwd_b=0 constantly; stall=1 whenever a used rs matches the rd (non-zero) of any valid RegWrite instruction in EX or MEM; WB matches rely on write-through register file.

Structure
REQ-036 Package pipe_ctrl_pkg holds opcode constants, ctrl_t struct (all control bits), fwd_sel_e enum (NONE=00, WB=01, MEM=10).
REQ-037 Combinational sub-module ctrl_decode implements REQ-018..REQ-021; pipe_controller instantiates it once.

Verification
REQ-038 LW x5 then ADD x6,x5,x7 (FWD_EN) -> stall=1 one cycle, ex_valid=0 next cycle, then fwd_a=2'b01 for the ADD.
REQ-039 ADD x3 then SUB x4,x3,x3 (FWD_EN) -> no stall, fwd_a=fwd_b=2'b10.
REQ-040 BR in EX with ex_branch_taken=1 while LW-use hazard in ID -> flush_ifid=1, stall=0, ID/EX bubble.
REQ-041 ADDI x0 then ADD x1,x0,x0 -> no stall, fwd 2'b00; opcode 1111111 -> illegal_op=1, bubble.
REQ-042 No FWD_EN: ADD x3 then ADD x4,x3,x1 -> stall exactly 2 cycles, stall_count=2.
REQ-043 Force 2^CNT_W+3 stall cycles -> stall_count holds all-ones; assert rst_n=0 mid-stall -> all outputs 0 asynchronously.
